// File: rtl/instrumented_adder_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : instrumented_adder_wrapper
//  Description : Caravel user-project wrapper around a 32-bit instrumented
//                adder. Operands and configuration arrive over the logic
//                analyser buses; one selected sum bit is inverted and fed
//                back into chosen A bits so the carry chain forms a clocked
//                ring whose toggles can be counted.
//  Config      : INSTR_TOGGLE_COUNTER_EN -- when defined the toggle counter
//                is built and drives la1_data_out; otherwise la1_data_out
//                is 0 and ctrl[7] has no effect.
//  Revision    : 1.0 - initial release
// ============================================================================
module instrumented_adder_wrapper (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        active,
  input  logic [31:0] la1_data_in,
  input  logic [31:0] la2_data_in,
  input  logic [31:0] la3_data_in,
  input  logic [31:0] la1_oenb,
  input  logic [31:0] la2_oenb,
  input  logic [31:0] la3_oenb,
  input  logic [37:0] io_in,
  output logic [31:0] la1_data_out,
  output logic [31:0] la2_data_out,
  output logic [31:0] la3_data_out,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  localparam logic [4:0]  c_SEL_RESET  = 5'd7;
  localparam logic [37:0] c_OEB_ACTIVE = 38'h3F_FFFF_FCFF;
  localparam logic [37:0] c_OEB_PARKED = {38{1'b1}};

  // Only enabled LA bits are honoured; disabled lanes read as zero.
  logic [31:0] w_d1;
  logic [31:0] w_d2;
  logic [31:0] w_ctrl;

  assign w_d1   = la1_data_in & ~la1_oenb;
  assign w_d2   = la2_data_in & ~la2_oenb;
  assign w_ctrl = la3_data_in & ~la3_oenb;

  logic [31:0] a_input_q, a_input_d;
  logic [31:0] b_input_q, b_input_d;
  logic [31:0] a_ext_q,   a_ext_d;
  logic [31:0] a_ring_q,  a_ring_d;
  logic [4:0]  s_sel_q,   s_sel_d;
  logic        chain_q,   chain_d;
  logic        run_q,     run_d;

  logic [31:0] w_a_eff;
  logic [31:0] w_sum;
  logic        w_carry;

  // Adder operates on the current register contents; ring bits take the
  // registered chain output instead of the static operand.
  always_comb begin
    w_a_eff            = (a_input_q & a_ext_q & ~a_ring_q) | (a_ring_q & {32{chain_q}});
    {w_carry, w_sum}   = {1'b0, w_a_eff} + {1'b0, b_input_q};
  end

  // Next-state for configuration, run flag and ring output; frozen when inactive.
  always_comb begin
    a_input_d = a_input_q;
    b_input_d = b_input_q;
    a_ext_d   = a_ext_q;
    a_ring_d  = a_ring_q;
    s_sel_d   = s_sel_q;
    chain_d   = chain_q;
    run_d     = run_q;
    if (active) begin
      if (w_ctrl[0]) a_input_d = w_d1;
      if (w_ctrl[1]) b_input_d = w_d2;
      if (w_ctrl[2]) a_ext_d   = w_d1;
      if (w_ctrl[3]) a_ring_d  = w_d2;
      if (w_ctrl[4]) s_sel_d   = w_d1[4:0];
      // Stop takes precedence over start when both are requested.
      if (w_ctrl[6])      run_d = 1'b0;
      else if (w_ctrl[5]) run_d = 1'b1;
      if (run_q) chain_d = ~w_sum[s_sel_q];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      a_input_q <= '0;
      b_input_q <= '0;
      a_ext_q   <= '0;
      a_ring_q  <= '0;
      s_sel_q   <= c_SEL_RESET;
      chain_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      a_input_q <= a_input_d;
      b_input_q <= b_input_d;
      a_ext_q   <= a_ext_d;
      a_ring_q  <= a_ring_d;
      s_sel_q   <= s_sel_d;
      chain_q   <= chain_d;
      run_q     <= run_d;
    end
  end

  logic [31:0] w_count;

`ifdef INSTR_TOGGLE_COUNTER_EN
  logic [31:0] counter_q, counter_d;

  // Count every edge where the ring output actually changes; clear wins.
  always_comb begin
    counter_d = counter_q;
    if (active) begin
      if (w_ctrl[7])               counter_d = '0;
      else if (chain_d != chain_q) counter_d = counter_q + 32'd1;
    end
  end

  // Toggle counter register.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) counter_q <= '0;
    else        counter_q <= counter_d;
  end

  assign w_count = counter_q;

  logic w_unused;
  assign w_unused = ^{io_in, w_ctrl[31:8]};
`else
  assign w_count = '0;

  logic w_unused;
  assign w_unused = ^{io_in, w_ctrl[31:7]};
`endif

  // Outputs are parked (zero data, all pads tri-stated) when not selected.
  always_comb begin
    la1_data_out = '0;
    la2_data_out = '0;
    la3_data_out = '0;
    io_out       = '0;
    io_oeb       = c_OEB_PARKED;
    if (active) begin
      la1_data_out = w_count;
      la2_data_out = w_sum;
      la3_data_out = {29'b0, run_q, w_carry, chain_q};
      io_out[8]    = chain_q;
      io_out[9]    = w_carry;
      io_oeb       = c_OEB_ACTIVE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instrumented_adder_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instrumented_adder_wrapper
//  Description : Scoreboard bench for instrumented_adder_wrapper. A driver
//                issues directed and random LA traffic and pushes the
//                expected post-edge outputs; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instrumented_adder_wrapper;

`ifdef INSTR_TOGGLE_COUNTER_EN
  localparam bit c_CNT_EN = 1'b1;
`else
  localparam bit c_CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        active = 1'b0;
  logic [31:0] la1_in = '0, la2_in = '0, la3_in = '0;
  logic [31:0] la1_oenb = '1, la2_oenb = '1, la3_oenb = '1;
  logic [37:0] io_in = '0;
  logic [31:0] la1_out, la2_out, la3_out;
  logic [37:0] io_out, io_oeb;

  always #5 clk = ~clk;

  instrumented_adder_wrapper dut (
    .wb_clk_i    (clk),
    .rst_n       (rst_n),
    .active      (active),
    .la1_data_in (la1_in),
    .la2_data_in (la2_in),
    .la3_data_in (la3_in),
    .la1_oenb    (la1_oenb),
    .la2_oenb    (la2_oenb),
    .la3_oenb    (la3_oenb),
    .io_in       (io_in),
    .la1_data_out(la1_out),
    .la2_data_out(la2_out),
    .la3_data_out(la3_out),
    .io_out      (io_out),
    .io_oeb      (io_oeb)
  );

  typedef struct packed {
    logic [31:0] l1;
    logic [31:0] l2;
    logic [31:0] l3;
    logic [37:0] io;
    logic [37:0] oeb;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state
  logic [31:0] m_a, m_b, m_ext, m_ring, m_cnt;
  int          m_sel;
  bit          m_chain, m_run;

  function automatic logic [32:0] ref_add();
    logic [31:0] aeff;
    aeff = (m_a & m_ext & ~m_ring) | (m_chain ? m_ring : 32'h0);
    return {1'b0, aeff} + {1'b0, m_b};
  endfunction

  task automatic step(input bit act, input bit rn,
                      input logic [31:0] d1r, input logic [31:0] o1,
                      input logic [31:0] d2r, input logic [31:0] o2,
                      input logic [31:0] c3r, input logic [31:0] o3);
    logic [31:0] d1, d2, c;
    logic [32:0] t;
    bit          nchain;
    exp_t        e;
    @(negedge clk);
    active = act; rst_n = rn;
    la1_in = d1r; la1_oenb = o1;
    la2_in = d2r; la2_oenb = o2;
    la3_in = c3r; la3_oenb = o3;
    io_in  = {$urandom, $urandom};
    d1 = d1r & ~o1; d2 = d2r & ~o2; c = c3r & ~o3;
    if (!rn) begin
      m_a = 0; m_b = 0; m_ext = 0; m_ring = 0; m_sel = 7;
      m_chain = 0; m_run = 0; m_cnt = 0;
    end else if (act) begin
      t = ref_add();
      nchain = m_run ? !t[m_sel] : m_chain;
      if (c[7])                 m_cnt = 0;
      else if (nchain != m_chain) m_cnt = m_cnt + 1;
      m_chain = nchain;
      if (c[6])      m_run = 0;
      else if (c[5]) m_run = 1;
      if (c[0]) m_a = d1;
      if (c[1]) m_b = d2;
      if (c[2]) m_ext = d1;
      if (c[3]) m_ring = d2;
      if (c[4]) m_sel = int'(d1 % 32);
    end
    t = ref_add();
    if (act) begin
      e.l1  = c_CNT_EN ? m_cnt : 32'h0;
      e.l2  = t[31:0];
      e.l3  = {29'h0, m_run, t[32], m_chain};
      e.io  = 38'h0 | (38'(t[32]) << 9) | (38'(m_chain) << 8);
      e.oeb = 38'h3F_FFFF_FCFF;
    end else begin
      e = '0;
      e.oeb = '1;
    end
    q.push_back(e);
  endtask

  task automatic ld(input logic [7:0] c, input logic [31:0] d1, input logic [31:0] d2);
    step(1, 1, d1, 0, d2, 0, {24'h0, c}, 0);
  endtask

  task automatic chk(input string nm, input logic [37:0] act, input logic [37:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational from registers, valid just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("la1_data_out", {6'h0, la1_out}, {6'h0, e.l1});
        chk("la2_data_out", {6'h0, la2_out}, {6'h0, e.l2});
        chk("la3_data_out", {6'h0, la3_out}, {6'h0, e.l3});
        chk("io_out", io_out, e.io);
        chk("io_oeb", io_oeb, e.oeb);
      end
    end
  end

  initial begin
    bit act, rn;
    // reset with active high
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // a=5, ext all ones, ring 0, b=3 -> sum 8
    ld(8'h0C, 32'hFFFF_FFFF, 32'h0);
    ld(8'h03, 32'd5, 32'd3);
    // all ones -> sum FFFFFFFE with carry
    ld(8'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // ring on bit 0, ext 0, a=b=0, sel=0, run + clear counter
    ld(8'h0C, 32'h0, 32'h1);
    ld(8'h13, 32'h0, 32'h0);
    ld(8'hA0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) ld(8'h00, 32'h0, 32'h0);
    // freeze for 5 cycles while issuing commands that must be ignored
    for (int i = 0; i < 5; i++) step(0, 1, $urandom, 0, $urandom, 0, 32'hFF, 0);
    ld(8'h00, 32'h0, 32'h0);
    // stop and clear together
    ld(8'hC0, 32'h0, 32'h0);
    ld(8'h00, 32'h0, 32'h0);
    // masked lanes: oenb hides everything
    step(1, 1, $urandom, '1, $urandom, '1, 32'hFF, '1);
    // reset mid-run
    ld(8'h20, 32'h0, 32'h0);
    ld(8'h00, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h3F, 0);
    ld(8'h00, 32'h0, 32'h0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      act = ($urandom_range(0, 9) != 0);
      rn  = ($urandom_range(0, 39) != 0);
      step(act, rn,
           ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom,
           ($urandom_range(0, 3) == 0) ? $urandom : 32'h0,
           ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : $urandom,
           ($urandom_range(0, 3) == 0) ? $urandom : 32'h0,
           {24'h0, 8'($urandom) & 8'($urandom)},
           ($urandom_range(0, 5) == 0) ? $urandom : 32'h0);
    end
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
